// File: rtl/memory_port_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one shared memory port,
// with one transaction outstanding and a starvation guard for the fetch side.
module memory_port_arbiter #(
    parameter int DATA_WIDTH       = 32,
    parameter int STARVATION_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  inst_request,
    input  logic [DATA_WIDTH-1:0] inst_address,
    output logic                  inst_address_ok,
    output logic                  inst_data_ok,
    output logic [DATA_WIDTH-1:0] inst_read_data,

    input  logic                  data_request,
    input  logic                  data_write,
    input  logic [3:0]            data_byte_enable,
    input  logic [DATA_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic                  data_address_ok,
    output logic                  data_data_ok,
    output logic [DATA_WIDTH-1:0] data_read_data,

    output logic                  mem_request,
    output logic                  mem_write,
    output logic [3:0]            mem_byte_enable,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_address_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int SW = $clog2(STARVATION_LIMIT + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVATION_LIMIT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t                r_state;
    owner_t                r_owner;
    logic [SW-1:0]         r_starve;
    logic                  r_mem_write;
    logic [3:0]            r_mem_byte_enable;
    logic [DATA_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_write_data;

    logic w_idle;
    logic w_starved;
    logic w_grant_data;
    logic w_grant_inst;
    logic w_complete;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_starved    = inst_request && (r_starve == STARVE_MAX);
    assign w_grant_data = w_idle && data_request && !w_starved;
    assign w_grant_inst = w_idle && inst_request && !w_grant_data;
    assign w_complete   = (r_state == ST_WAIT) && mem_data_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_owner           <= OWN_INST;
            r_starve          <= '0;
            r_mem_write       <= 1'b0;
            r_mem_byte_enable <= '0;
            r_mem_address     <= '0;
            r_mem_write_data  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant_data) begin
                        r_state           <= ST_ISSUE;
                        r_owner           <= OWN_DATA;
                        r_mem_write       <= data_write;
                        r_mem_byte_enable <= data_byte_enable;
                        r_mem_address     <= data_address;
                        r_mem_write_data  <= data_write_data;
                        // Only a contested data grant counts toward fetch starvation.
                        if (!inst_request)
                            r_starve <= '0;
                        else if (r_starve != STARVE_MAX)
                            r_starve <= r_starve + 1'b1;
                    end else if (w_grant_inst) begin
                        r_state           <= ST_ISSUE;
                        r_owner           <= OWN_INST;
                        r_mem_write       <= 1'b0;
                        r_mem_byte_enable <= '1;
                        r_mem_address     <= inst_address;
                        r_mem_write_data  <= '0;
                        r_starve          <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_address_ok)
                        r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_data_ok)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Grants are combinational, so gate them with reset to keep outputs quiet in reset.
    assign inst_address_ok = reset_n && w_grant_inst;
    assign data_address_ok = reset_n && w_grant_data;

    assign inst_data_ok    = w_complete && (r_owner == OWN_INST);
    assign data_data_ok    = w_complete && (r_owner == OWN_DATA);
    assign inst_read_data  = inst_data_ok ? mem_read_data : '0;
    assign data_read_data  = data_data_ok ? mem_read_data : '0;

    assign mem_request     = (r_state == ST_ISSUE);
    assign mem_write       = r_mem_write;
    assign mem_byte_enable = r_mem_byte_enable;
    assign mem_address     = r_mem_address;
    assign mem_write_data  = r_mem_write_data;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: transaction-level model checked every
// cycle, a configurable memory responder, and directed scenarios with literal checks.
module tb_memory_port_arbiter;

    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          inst_request;
    logic [DW-1:0] inst_address;
    logic          inst_address_ok, inst_data_ok;
    logic [DW-1:0] inst_read_data;
    logic          data_request, data_write;
    logic [3:0]    data_byte_enable;
    logic [DW-1:0] data_address, data_write_data;
    logic          data_address_ok, data_data_ok;
    logic [DW-1:0] data_read_data;
    logic          mem_request, mem_write;
    logic [3:0]    mem_byte_enable;
    logic [DW-1:0] mem_address, mem_write_data;
    logic          mem_address_ok, mem_data_ok;
    logic [DW-1:0] mem_read_data;

    memory_port_arbiter #(.DATA_WIDTH(DW), .STARVATION_LIMIT(LIM)) dut (
        .clock(clock), .reset_n(reset_n),
        .inst_request(inst_request), .inst_address(inst_address),
        .inst_address_ok(inst_address_ok), .inst_data_ok(inst_data_ok),
        .inst_read_data(inst_read_data),
        .data_request(data_request), .data_write(data_write),
        .data_byte_enable(data_byte_enable), .data_address(data_address),
        .data_write_data(data_write_data), .data_address_ok(data_address_ok),
        .data_data_ok(data_data_ok), .data_read_data(data_read_data),
        .mem_request(mem_request), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_address_ok(mem_address_ok),
        .mem_data_ok(mem_data_ok), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: accepts after acc_delay ISSUE cycles, returns data data_delay cycles later.
    int            acc_delay = 0, data_delay = 0;
    bit            ovr_en = 0;
    logic [DW-1:0] ovr = '0;
    bit            force_dok = 0;
    bit            resp_aok = 0, resp_dok = 0, pend = 0;
    int            acnt = 0, dcnt = 0;
    logic [DW-1:0] cap_addr = '0, resp_rd = '0;

    assign mem_address_ok = resp_aok;
    assign mem_data_ok    = resp_dok | force_dok;
    assign mem_read_data  = resp_rd;

    always @(posedge clock) begin
        bit was_acc, rst_seen;
        was_acc  = mem_request && mem_address_ok;
        rst_seen = !reset_n;
        if (was_acc) cap_addr = mem_address;
        #1;
        resp_dok = 0;
        resp_rd  = 32'(cyc) ^ 32'hC0DE_0000;
        if (rst_seen) begin
            pend = 0; acnt = 0; dcnt = 0; resp_aok = 0;
        end else begin
            if (was_acc) begin pend = 1; dcnt = 0; end
            if (pend) begin
                if (dcnt == data_delay) begin
                    resp_dok = 1;
                    resp_rd  = ovr_en ? ovr : (cap_addr ^ 32'h5A5A_5A5A);
                    pend     = 0;
                end else dcnt++;
            end
            if (mem_request) begin
                if (acnt == acc_delay) begin resp_aok = 1; acnt = 0; end
                else begin resp_aok = 0; acnt++; end
            end else begin
                resp_aok = 0; acnt = 0;
            end
        end
    end

    // Observation log of what the DUT actually did.
    string         glog = "";
    int            n_memreq = 0, n_idok = 0, n_ddok = 0;
    int            t_iaok = 0, t_idok = 0, t_ddok = 0;
    logic [DW-1:0] v_idok = '0;
    always @(negedge clock) begin
        if (inst_address_ok) begin glog = {glog, "I"}; t_iaok = cyc; end
        if (data_address_ok) glog = {glog, "D"};
        if (mem_request) n_memreq++;
        if (inst_data_ok) begin n_idok++; t_idok = cyc; v_idok = inst_read_data; end
        if (data_data_ok) begin n_ddok++; t_ddok = cyc; end
    end

    // Transaction-level model: one outstanding transaction, accepted then completed.
    bit       m_busy = 0, m_acc = 0, m_own_data = 0, m_write = 0;
    bit [3:0] m_be = '0;
    bit [31:0] m_addr = '0, m_wdata = '0;
    int       m_starv = 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_acc = 0; m_own_data = 0; m_write = 0;
            m_be = '0; m_addr = '0; m_wdata = '0; m_starv = 0;
        end else if (!m_busy) begin
            if (data_request && !(inst_request && m_starv == LIM)) begin
                m_busy = 1; m_own_data = 1; m_write = data_write; m_be = data_byte_enable;
                m_addr = data_address; m_wdata = data_write_data;
                m_starv = inst_request ? ((m_starv < LIM) ? m_starv + 1 : LIM) : 0;
            end else if (inst_request) begin
                m_busy = 1; m_own_data = 0; m_write = 0; m_be = 4'hF;
                m_addr = inst_address; m_wdata = '0; m_starv = 0;
            end
        end else if (!m_acc) begin
            if (mem_address_ok) m_acc = 1;
        end else if (mem_data_ok) begin
            m_busy = 0; m_acc = 0;
        end
    end

    bit chk_en = 0;
    always @(negedge clock) begin
        logic          e_ga, e_gi, e_dd, e_di, e_req;
        logic [DW-1:0] e_rd, e_ri;
        if (chk_en) begin
            e_ga = 0; e_gi = 0; e_dd = 0; e_di = 0; e_req = 0;
            if (reset_n) begin
                e_ga  = !m_busy && data_request && !(inst_request && m_starv == LIM);
                e_gi  = !m_busy && inst_request && !e_ga;
                e_req = m_busy && !m_acc;
                e_dd  = m_busy && m_acc && mem_data_ok && m_own_data;
                e_di  = m_busy && m_acc && mem_data_ok && !m_own_data;
            end
            e_rd = e_dd ? mem_read_data : '0;
            e_ri = e_di ? mem_read_data : '0;
            chk("addr_ok", 128'({inst_address_ok, data_address_ok}), 128'({e_gi, e_ga}));
            chk("data_ok", 128'({inst_data_ok, data_data_ok}), 128'({e_di, e_dd}));
            chk("read_data", 128'({inst_read_data, data_read_data}), 128'({e_ri, e_rd}));
            chk("mem_request", 128'(mem_request), 128'(e_req));
            if (!reset_n)
                chk("mem_fields_rst", 128'({mem_write, mem_byte_enable, mem_address, mem_write_data}), 128'(0));
            else if (e_req)
                chk("mem_fields", 128'({mem_write, mem_byte_enable, mem_address, mem_write_data}),
                    128'({m_write, m_be, m_addr, m_wdata}));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event within bound, required event", name);
    endtask

    task automatic wait_aok(input bit side_data, input int lim, input string name);
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (side_data ? data_address_ok : inst_address_ok) return;
        end
        timeout(name);
    endtask

    task automatic wait_dok(input bit side_data, input int lim, input string name);
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (side_data ? data_data_ok : inst_data_ok) return;
        end
        timeout(name);
    endtask

    task automatic wait_memreq_low(input int lim, input string name);
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (!mem_request) return;
        end
        timeout(name);
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, s, n0, d0, i0;
        reset_n = 0;
        inst_request = 0; inst_address = '0;
        data_request = 0; data_write = 0; data_byte_enable = '0;
        data_address = '0; data_write_data = '0;
        chk_en = 1;
        #1;
        chk("rst_side_outputs", 128'({inst_address_ok, inst_data_ok, inst_read_data,
            data_address_ok, data_data_ok, data_read_data}), 128'(0));
        tick();
        tick();
        reset_n = 1;

        // Single fetch at minimum latency.
        ovr_en = 1; ovr = 32'h2408_0001;
        inst_request = 1; inst_address = 32'hBFC0_0000;
        @(negedge clock);
        chk("t1_iaok", 128'(inst_address_ok), 128'(1));
        g = cyc;
        tick();
        inst_request = 0; inst_address = '0;
        @(negedge clock);
        chk("t1_memreq", 128'({mem_request, mem_write, mem_byte_enable, mem_address, mem_write_data}),
            128'({1'b1, 1'b0, 4'hF, 32'hBFC0_0000, 32'h0}));
        wait_dok(0, 20, "t1_idok");
        tick();
        chk("t1_latency", 128'(t_idok - g), 128'(2));
        chk("t1_rdata", 128'(v_idok), 128'(32'h2408_0001));
        ovr_en = 0;

        // Simultaneous requests: data first, fetch the cycle after data completes.
        s = glog.len();
        data_request = 1; data_write = 0; data_byte_enable = 4'hF; data_address = 32'h2000;
        inst_request = 1; inst_address = 32'h3000;
        @(negedge clock);
        chk("t2_grant", 128'({data_address_ok, inst_address_ok}), 128'(2'b10));
        tick();
        data_request = 0;
        wait_aok(0, 20, "t2_iaok");
        tick();
        inst_request = 0;
        chk("t2_after", 128'(t_iaok - t_ddok), 128'(1));
        wait_dok(0, 20, "t2_idok");
        tick();
        chk("t2_order", 128'(glog.substr(s, s + 1) == "DI"), 128'(1));

        // Both held continuously: starvation guard lets fetch through every fifth grant.
        do_reset();
        s = glog.len();
        data_request = 1; data_write = 0; data_address = 32'h4000;
        inst_request = 1; inst_address = 32'h5000;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (glog.len() - s >= 10) break;
        end
        data_request = 0; inst_request = 0;
        repeat (6) tick();
        chk("t3_count", 128'(glog.len() - s), 128'(10));
        chk("t3_order", 128'(glog.substr(s, s + 9) == "DDDDIDDDDI"), 128'(1));

        // Store with delayed acceptance; inputs change after the grant.
        acc_delay = 3; data_delay = 1;
        n0 = n_memreq; d0 = n_ddok;
        data_request = 1; data_write = 1; data_byte_enable = 4'b0011;
        data_address = 32'h1000; data_write_data = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("t4_daok", 128'(data_address_ok), 128'(1));
        tick();
        data_request = 0; data_write = 0; data_byte_enable = 4'hF;
        data_address = 32'hFFFF_FFFF; data_write_data = '0;
        @(negedge clock);
        chk("t4_fields", 128'({mem_request, mem_write, mem_byte_enable, mem_address, mem_write_data}),
            128'({1'b1, 1'b1, 4'b0011, 32'h1000, 32'hDEAD_BEEF}));
        wait_dok(1, 30, "t4_ddok");
        tick();
        repeat (3) tick();
        chk("t4_issue_cycles", 128'(n_memreq - n0), 128'(4));
        chk("t4_ddok_once", 128'(n_ddok - d0), 128'(1));
        acc_delay = 0; data_delay = 0;

        // Reset while waiting for data abandons the transaction.
        data_delay = 5;
        i0 = n_idok; d0 = n_ddok;
        inst_request = 1; inst_address = 32'h6000;
        @(negedge clock);
        chk("t5_iaok", 128'(inst_address_ok), 128'(1));
        tick();
        inst_request = 0;
        wait_memreq_low(20, "t5_wait");
        tick();
        reset_n = 0;
        @(negedge clock);
        chk("t5_rst_side", 128'({inst_address_ok, inst_data_ok, inst_read_data,
            data_address_ok, data_data_ok, data_read_data}), 128'(0));
        chk("t5_rst_mem", 128'({mem_request, mem_write, mem_byte_enable, mem_address, mem_write_data}),
            128'(0));
        tick();
        tick();
        reset_n = 1;
        force_dok = 1;
        @(negedge clock);
        chk("t5_no_dok", 128'({inst_data_ok, data_data_ok}), 128'(0));
        tick();
        force_dok = 0;
        repeat (8) tick();
        chk("t5_dok_count", 128'((n_idok - i0) + (n_ddok - d0)), 128'(0));
        data_delay = 0;
        inst_request = 1; inst_address = 32'h7000;
        @(negedge clock);
        chk("t5_idle_grant", 128'(inst_address_ok), 128'(1));
        tick();
        inst_request = 0;
        wait_dok(0, 20, "t5_idok");
        tick();

        // Spurious mem_data_ok in IDLE and in ISSUE is ignored.
        force_dok = 1;
        @(negedge clock);
        chk("t6_idle_quiet", 128'({inst_address_ok, data_address_ok, inst_data_ok, data_data_ok}),
            128'(0));
        tick();
        force_dok = 0;
        acc_delay = 2;
        inst_request = 1; inst_address = 32'h8000;
        @(negedge clock);
        chk("t6_grant", 128'(inst_address_ok), 128'(1));
        tick();
        inst_request = 0;
        force_dok = 1;
        @(negedge clock);
        chk("t6_issue_quiet", 128'({mem_request, inst_data_ok, data_data_ok}), 128'(3'b100));
        tick();
        force_dok = 0;
        wait_dok(0, 20, "t6_idok");
        tick();
        acc_delay = 0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
